// File: rtl/mmul_regb_ctrl.sv
// mmul_regb_ctrl
// Sequencer that drives the control port of the Montgomery-multiplier
// B-operand register (257-bit, 16-bit cyclic port, 1-bit left-shift mode).
// Host commands LOAD / SHIFT / READ are turned into we / sel_cyc / sel_ls /
// regin strobes for that register.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   cmd_valid/ready   command handshake (ready only in IDLE)
//   cmd_op            00 LOAD, 01 SHIFT, 10 READ, 11 no-op
//   cmd_arg           shift count for SHIFT
//   din/_valid/_ready load word stream, LS word first
//   dout/_valid/_ready read word stream, LS word first
//   busy, done        status; done pulses once per operation
//   ovf               bit 256 captured when a non-zero SHIFT completes
//   regb_*            controls to / observation from the B register
module mmul_regb_ctrl #(
    parameter int W      = 16,
    parameter int NWORDS = 16,
    parameter int CNT_W  = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [W-1:0]     dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [W-1:0]     regb_regin,
    output logic             regb_we,
    output logic             regb_sel_cyc,
    output logic             regb_sel_ls,
    input  logic [W-1:0]     regb_regout,
    input  logic             regb_b256
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_READ,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [CNT_W-1:0] arg;
    } cmd_t;

    localparam logic [1:0]       OP_LOAD   = 2'b00;
    localparam logic [1:0]       OP_SHIFT  = 2'b01;
    localparam logic [1:0]       OP_READ   = 2'b10;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    state_t           state;
    cmd_t             cmd_q;
    logic [CNT_W-1:0] cnt;

    // Word strobes: a word moves only when both sides agree this cycle.
    logic load_fire;
    logic read_fire;

    assign load_fire = (state == S_LOAD) && din_valid;
    assign read_fire = (state == S_READ) && dout_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cmd_q <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        cmd_q.op  <= cmd_op;
                        cmd_q.arg <= cmd_arg;
                        cnt       <= '0;
                        case (cmd_op)
                            OP_LOAD: begin
                                state <= S_LOAD;
                                ovf   <= 1'b0;
                            end
                            OP_SHIFT: state <= (cmd_arg == '0) ? S_DONE : S_SHIFT;
                            OP_READ:  state <= S_READ;
                            default:  state <= S_DONE;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (load_fire) begin
                        cnt <= cnt + ONE;
                        if (cnt == LAST_WORD) state <= S_DONE;
                    end
                end
                S_SHIFT: begin
                    // No stall: one shift per cycle until arg shifts issued.
                    cnt <= cnt + ONE;
                    if (cnt == cmd_q.arg - ONE) state <= S_DONE;
                end
                S_READ: begin
                    if (read_fire) begin
                        cnt <= cnt + ONE;
                        if (cnt == LAST_WORD) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // The last shift lands on the edge entering DONE, so b256
                    // is settled here.
                    if (cmd_q.op == OP_SHIFT && cmd_q.arg != '0) ovf <= regb_b256;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Register strobes are combinational so a word is consumed in the same
    // cycle it is offered; reset forces IDLE and therefore all-zero strobes.
    assign cmd_ready    = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign din_ready    = (state == S_LOAD);
    assign dout_valid   = (state == S_READ);
    assign dout         = (state == S_READ) ? regb_regout : '0;
    assign regb_regin   = (state == S_LOAD) ? din : '0;
    assign regb_we      = load_fire || read_fire || (state == S_SHIFT);
    assign regb_sel_cyc = read_fire;
    assign regb_sel_ls  = (state == S_SHIFT);

endmodule
